// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   OP_ADD/OP_SUB/OP_MUL/OP_DIV : 2-bit ALU op-select encodings
//   seq_state_t                 : sequencer FSM states
//   DATA_W_DEF                  : default operand/result width (matches the ALU)
package alu_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the sequencer's request, response and ALU-side signals.
//   req_valid/req_ready/req_a/req_b/req_sel : request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_overflow/rsp_sel : response channel
//   alu_ina/alu_inb/alu_sel : registered operands and select to the ALU
//   alu_out/alu_overflow    : ALU result and overflow back to the sequencer
// Modports:
//   master : environment side (requester, response consumer and the ALU)
//   slave  : the sequencer itself
interface alu_op_sequencer_if #(parameter int DATA_W = 16);

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [1:0]        req_sel;

    logic [DATA_W-1:0] alu_ina;
    logic [DATA_W-1:0] alu_inb;
    logic [1:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic              alu_overflow;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_overflow;
    logic [1:0]        rsp_sel;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready, alu_out, alu_overflow,
        input  req_ready, rsp_valid, rsp_data, rsp_overflow, rsp_sel,
               alu_ina, alu_inb, alu_sel
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready, alu_out, alu_overflow,
        output req_ready, rsp_valid, rsp_data, rsp_overflow, rsp_sel,
               alu_ina, alu_inb, alu_sel
    );

endinterface

// File: rtl/alu_settle_counter.sv
// Loadable down-counter that times the ALU settle window.
//   clk, rst : clock and synchronous active-high reset
//   load     : load load_val (takes priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one; saturates at zero
//   zero     : counter currently equals zero
module alu_settle_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Requester-side driver for the 16-bit four-function combinational ALU.
// Accepts a request, registers operands/select onto the ALU inputs, holds
// them for SETTLE_CYCLES, captures result/overflow and offers them on the
// response channel until accepted. One operation in flight at a time.
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_op_sequencer_if.slave (request, response, ALU signals)
//   busy     : high whenever the FSM is not in IDLE
// Optional build macro ALU_SEQ_DIV0_TRAP_EN: divide requests with a zero
// divisor are answered locally (all-ones data, overflow set) on the accept
// edge instead of being issued to the ALU.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus,
    output logic                busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_t state, state_nxt;

    logic              accept;
    logic              div0_trap;
    logic              cnt_zero;
    logic              capture;
    logic [DATA_W-1:0] alu_ina_q;
    logic [DATA_W-1:0] alu_inb_q;
    logic [1:0]        alu_sel_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_ovf_q;
    logic [1:0]        rsp_sel_q;

    assign accept  = bus.req_valid && (state == ST_IDLE);
    assign capture = (state == ST_SETTLE) && cnt_zero;

`ifdef ALU_SEQ_DIV0_TRAP_EN
    assign div0_trap = (bus.req_sel == OP_DIV) && (bus.req_b == '0);
`else
    assign div0_trap = 1'b0;
`endif

    alu_settle_counter #(.CNT_W(4)) u_settle_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (SETTLE_LOAD),
        .dec      (state == ST_SETTLE),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = div0_trap ? ST_RESP : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU input registers and response capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ina_q  <= '0;
            alu_inb_q  <= '0;
            alu_sel_q  <= OP_ADD;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_sel_q  <= OP_ADD;
        end else begin
            // A trapped divide leaves the ALU inputs on their previous operands.
            if (accept && !div0_trap) begin
                alu_ina_q <= bus.req_a;
                alu_inb_q <= bus.req_b;
                alu_sel_q <= bus.req_sel;
            end
            if (capture) begin
                rsp_data_q <= bus.alu_out;
                rsp_ovf_q  <= bus.alu_overflow;
                rsp_sel_q  <= alu_sel_q;
            end else if (accept && div0_trap) begin
                rsp_data_q <= '1;
                rsp_ovf_q  <= 1'b1;
                rsp_sel_q  <= OP_DIV;
            end
        end
    end

    assign bus.req_ready    = (state == ST_IDLE);
    assign bus.rsp_valid    = (state == ST_RESP);
    assign bus.alu_ina      = alu_ina_q;
    assign bus.alu_inb      = alu_inb_q;
    assign bus.alu_sel      = alu_sel_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.rsp_sel      = rsp_sel_q;
    assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer. Two instances: SETTLE_CYCLES=1
// (u_dut1) and SETTLE_CYCLES=3 (u_dut3), each with a combinational ALU model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic busy1, busy3;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DATA_W(16)) if1 ();
    alu_op_sequencer_if #(.DATA_W(16)) if3 ();

    // Reference ALU: {overflow, result}
    function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [1:0] s);
        logic [15:0] r;
        logic [31:0] p;
        logic        v;
        r = '0;
        v = 1'b0;
        p = '0;
        case (s)
            2'b00: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            2'b01: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            2'b10: begin p = a * b; r = p[15:0]; v = |p[31:16]; end
            default: begin
                if (b == 16'h0) begin r = 16'hFFFF; v = 1'b1; end
                else            begin r = a / b;    v = 1'b0; end
            end
        endcase
        return {v, r};
    endfunction

    assign {if1.alu_overflow, if1.alu_out} = alu_model(if1.alu_ina, if1.alu_inb, if1.alu_sel);
    assign {if3.alu_overflow, if3.alu_out} = alu_model(if3.alu_ina, if3.alu_inb, if3.alu_sel);

    alu_op_sequencer #(.DATA_W(16), .SETTLE_CYCLES(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1), .busy (busy1)
    );

    alu_op_sequencer #(.DATA_W(16), .SETTLE_CYCLES(3)) u_dut3 (
        .clk (clk), .rst (rst), .bus (if3), .busy (busy3)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present1(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        if1.req_a = a; if1.req_b = b; if1.req_sel = s; if1.req_valid = 1'b1;
    endtask

    task automatic present3(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        if3.req_a = a; if3.req_b = b; if3.req_sel = s; if3.req_valid = 1'b1;
    endtask

    // Edges counted including the accept edge until rsp_valid is seen.
    task automatic wait_rsp1(output int lat);
        tick();
        lat = 1;
        if1.req_valid = 1'b0;
        while (!if1.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_rsp3(output int lat);
        tick();
        lat = 1;
        if3.req_valid = 1'b0;
        while (!if3.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release1;
        if1.rsp_ready = 1'b1;
        tick();
        if1.rsp_ready = 1'b0;
    endtask

    task automatic release3;
        if3.rsp_ready = 1'b1;
        tick();
        if3.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if ({if1.req_ready, if1.rsp_valid, busy1} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_ctrl1: got %b expected 100", {if1.req_ready, if1.rsp_valid, busy1});
        end
        tests_run++;
        if ({if1.alu_ina, if1.alu_inb, if1.alu_sel, if1.rsp_data, if1.rsp_overflow, if1.rsp_sel} !== 53'h0) begin
            tests_failed++;
            $display("FAIL reset_data1: got %h expected 0",
                     {if1.alu_ina, if1.alu_inb, if1.alu_sel, if1.rsp_data, if1.rsp_overflow, if1.rsp_sel});
        end
        tests_run++;
        if ({if3.req_ready, if3.rsp_valid, busy3} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_ctrl3: got %b expected 100", {if3.req_ready, if3.rsp_valid, busy3});
        end
    endtask

    task automatic test_add_basic;
        present1(16'h0003, 16'h0004, 2'b00);
        tick();
        if1.req_valid = 1'b0;
        tests_run++;
        if ({if1.alu_ina, if1.alu_inb, if1.alu_sel} !== {16'h0003, 16'h0004, 2'b00}) begin
            tests_failed++;
            $display("FAIL add_alu_inputs: got %h/%h/%b expected 0003/0004/00",
                     if1.alu_ina, if1.alu_inb, if1.alu_sel);
        end
        tests_run++;
        if ({if1.req_ready, if1.rsp_valid, busy1} !== 3'b001) begin
            tests_failed++;
            $display("FAIL add_settle_ctrl: got %b expected 001", {if1.req_ready, if1.rsp_valid, busy1});
        end
        tick();
        tests_run++;
        if ({if1.rsp_valid, if1.rsp_data, if1.rsp_overflow, if1.rsp_sel} !== {1'b1, 16'h0007, 1'b0, 2'b00}) begin
            tests_failed++;
            $display("FAIL add_rsp: got v=%b d=%h o=%b s=%b expected v=1 d=0007 o=0 s=00",
                     if1.rsp_valid, if1.rsp_data, if1.rsp_overflow, if1.rsp_sel);
        end
        release1();
        tests_run++;
        if ({if1.rsp_valid, if1.req_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL add_release: got v=%b r=%b expected v=0 r=1", if1.rsp_valid, if1.req_ready);
        end
    endtask

    task automatic test_overflow;
        int lat;
        present1(16'h7FFF, 16'h0001, 2'b00);
        wait_rsp1(lat);
        tests_run++;
        if ({lat[7:0], if1.rsp_data, if1.rsp_overflow} !== {8'd2, 16'h8000, 1'b1}) begin
            tests_failed++;
            $display("FAIL add_ovf: got lat=%0d d=%h o=%b expected lat=2 d=8000 o=1",
                     lat, if1.rsp_data, if1.rsp_overflow);
        end
        release1();
        present1(16'h0005, 16'h0009, 2'b01);
        wait_rsp1(lat);
        tests_run++;
        if ({lat[7:0], if1.rsp_data, if1.rsp_overflow, if1.rsp_sel} !== {8'd2, 16'hFFFC, 1'b0, 2'b01}) begin
            tests_failed++;
            $display("FAIL sub_neg: got lat=%0d d=%h o=%b s=%b expected lat=2 d=fffc o=0 s=01",
                     lat, if1.rsp_data, if1.rsp_overflow, if1.rsp_sel);
        end
        release1();
    endtask

    task automatic test_settle3;
        present3(16'h0010, 16'h0020, 2'b10);
        tick();
        if3.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({if3.alu_ina, if3.alu_inb, if3.alu_sel, if3.rsp_valid} !== {16'h0010, 16'h0020, 2'b10, 1'b0}) begin
                tests_failed++;
                $display("FAIL mul_hold[%0d]: got %h/%h/%b v=%b expected 0010/0020/10 v=0",
                         i, if3.alu_ina, if3.alu_inb, if3.alu_sel, if3.rsp_valid);
            end
            tick();
        end
        tests_run++;
        if ({if3.rsp_valid, if3.rsp_data, if3.rsp_overflow, if3.rsp_sel} !== {1'b1, 16'h0200, 1'b0, 2'b10}) begin
            tests_failed++;
            $display("FAIL mul_rsp: got v=%b d=%h o=%b s=%b expected v=1 d=0200 o=0 s=10",
                     if3.rsp_valid, if3.rsp_data, if3.rsp_overflow, if3.rsp_sel);
        end
        release3();
    endtask

    task automatic test_back_to_back;
        int lat;
        present1(16'h0001, 16'h0002, 2'b00);
        wait_rsp1(lat);
        present1(16'h0009, 16'h0009, 2'b00);
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({if1.req_ready, if1.rsp_valid, if1.rsp_data} !== {1'b0, 1'b1, 16'h0003}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got r=%b v=%b d=%h expected r=0 v=1 d=0003",
                         i, if1.req_ready, if1.rsp_valid, if1.rsp_data);
            end
            tick();
        end
        release1();
        tests_run++;
        if ({if1.req_ready, if1.rsp_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_release: got r=%b v=%b expected r=1 v=0", if1.req_ready, if1.rsp_valid);
        end
        wait_rsp1(lat);
        tests_run++;
        if ({lat[7:0], if1.alu_ina, if1.rsp_data} !== {8'd2, 16'h0009, 16'h0012}) begin
            tests_failed++;
            $display("FAIL bp_next: got lat=%0d a=%h d=%h expected lat=2 a=0009 d=0012",
                     lat, if1.alu_ina, if1.rsp_data);
        end
        release1();
    endtask

    task automatic test_div0;
        int lat;
        present1(16'h1234, 16'h0000, 2'b11);
        wait_rsp1(lat);
        tests_run++;
        if ({if1.rsp_data, if1.rsp_overflow, if1.rsp_sel} !== {16'hFFFF, 1'b1, 2'b11}) begin
            tests_failed++;
            $display("FAIL div0_rsp: got d=%h o=%b s=%b expected d=ffff o=1 s=11",
                     if1.rsp_data, if1.rsp_overflow, if1.rsp_sel);
        end
`ifdef ALU_SEQ_DIV0_TRAP_EN
        tests_run++;
        if ({lat[7:0], if1.alu_ina, if1.alu_inb, if1.alu_sel} !== {8'd1, 16'h0009, 16'h0009, 2'b00}) begin
            tests_failed++;
            $display("FAIL div0_trap: got lat=%0d %h/%h/%b expected lat=1 0009/0009/00",
                     lat, if1.alu_ina, if1.alu_inb, if1.alu_sel);
        end
`else
        tests_run++;
        if ({lat[7:0], if1.alu_ina, if1.alu_inb, if1.alu_sel} !== {8'd2, 16'h1234, 16'h0000, 2'b11}) begin
            tests_failed++;
            $display("FAIL div0_issue: got lat=%0d %h/%h/%b expected lat=2 1234/0000/11",
                     lat, if1.alu_ina, if1.alu_inb, if1.alu_sel);
        end
`endif
        release1();
    endtask

    task automatic test_div_normal;
        int lat;
        present3(16'h0064, 16'h0005, 2'b11);
        wait_rsp3(lat);
        tests_run++;
        if ({lat[7:0], if3.rsp_data, if3.rsp_overflow, if3.rsp_sel} !== {8'd4, 16'h0014, 1'b0, 2'b11}) begin
            tests_failed++;
            $display("FAIL div_rsp: got lat=%0d d=%h o=%b s=%b expected lat=4 d=0014 o=0 s=11",
                     lat, if3.rsp_data, if3.rsp_overflow, if3.rsp_sel);
        end
        release3();
    endtask

    task automatic test_reset_mid;
        present3(16'h0005, 16'h0006, 2'b00);
        tick();
        if3.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({if3.req_ready, if3.rsp_valid, busy3, if3.alu_ina, if3.alu_inb, if3.alu_sel} !== {3'b100, 34'h0}) begin
            tests_failed++;
            $display("FAIL rst_mid: got r=%b v=%b b=%b %h/%h/%b expected r=1 v=0 b=0 0000/0000/00",
                     if3.req_ready, if3.rsp_valid, busy3, if3.alu_ina, if3.alu_inb, if3.alu_sel);
        end
        if3.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (if3.rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_norsp[%0d]: got v=%b expected v=0", i, if3.rsp_valid);
            end
        end
        if3.rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if1.req_valid = 1'b0; if1.req_a = '0; if1.req_b = '0; if1.req_sel = '0; if1.rsp_ready = 1'b0;
        if3.req_valid = 1'b0; if3.req_a = '0; if3.req_b = '0; if3.req_sel = '0; if3.rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_basic();
        test_overflow();
        test_settle3();
        test_back_to_back();
        test_div0();
        test_div_normal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
